// File: rtl/bht_gshare_update_pkg.sv
// Shared definitions for the gshare branch history table.
//   cfg_t          : core configuration subset used here (VLEN, RVC)
//   cva6_cfg_empty : default configuration (32-bit VLEN, compressed ISA on)
//   ctr_t          : 2-bit saturating direction counter
//   WEAK_NT        : weakly-not-taken counter value written by the init sweep
//   bht_state_e    : table state (INIT sweep, RUN)
//   gshare_index   : PC/history hash, also used by the frontend predict path
package bht_gshare_update_pkg;

    typedef struct packed {
        int unsigned VLEN;
        logic        RVC;
    } cfg_t;

    localparam cfg_t cva6_cfg_empty = '{VLEN: 32, RVC: 1'b1};

    typedef logic [1:0] ctr_t;

    localparam ctr_t WEAK_NT = 2'b01;

    typedef enum logic {
        INIT,
        RUN
    } bht_state_e;

    // Index = pc[off+iw-1:off] ^ zero-extended history, masked to iw bits.
    // Operands are passed zero-extended to 64 bits so one helper serves
    // every VLEN / table size; callers truncate the result to their width.
    function automatic logic [63:0] gshare_index(
        input logic [63:0] pc,
        input logic [63:0] ghr,
        input int unsigned off,
        input int unsigned iw
    );
        logic [63:0] mask;
        mask = (64'd1 << iw) - 64'd1;
        return ((pc >> off) ^ ghr) & mask;
    endfunction

endpackage

// File: rtl/bht_gshare_update_sat_counter_2b.sv
// Combinational 2-bit saturating counter step.
//   ctr      : current counter value
//   taken    : resolved direction (1 = increment, 0 = decrement)
//   ctr_next : min(ctr+1, 3) when taken, max(ctr-1, 0) otherwise
module sat_counter_2b
    import bht_gshare_update_pkg::*;
(
    input  ctr_t ctr,
    input  logic taken,
    output ctr_t ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != 2'b11) begin
                ctr_next = ctr + 2'b01;
            end
        end else begin
            if (ctr != 2'b00) begin
                ctr_next = ctr - 2'b01;
            end
        end
    end

endmodule

// File: rtl/bht_gshare_update.sv
// Gshare branch history table: 2-bit counters indexed by PC XOR history,
// with a two-stage update pipeline and a combinational lookup port.
// After reset the table is swept to weakly-not-taken, one entry per cycle.
//   clk_i, rst_ni    : clock (rising edge), asynchronous active-low reset
//   debug_mode_i     : drops updates while high
//   update_valid_i   : resolved conditional branch this cycle
//   update_pc_i      : branch PC
//   update_taken_i   : resolved direction
//   update_ghr_i     : history snapshot captured at predict time
//   lookup_pc_i      : fetch PC to predict
//   lookup_ghr_i     : current speculative history
//   lookup_ctr_o     : counter at the lookup index (2'b01 until ready)
//   lookup_taken_o   : predicted direction, lookup_ctr_o[1]
//   ready_o          : high once the init sweep has completed
module bht_gshare_update
    import bht_gshare_update_pkg::*;
#(
    parameter cfg_t        CVA6Cfg    = cva6_cfg_empty,
    parameter int unsigned NR_ENTRIES = 1024,
    parameter int unsigned GHR_LEN    = 10
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    debug_mode_i,
    input  logic                    update_valid_i,
    input  logic [CVA6Cfg.VLEN-1:0] update_pc_i,
    input  logic                    update_taken_i,
    input  logic [GHR_LEN-1:0]      update_ghr_i,
    input  logic [CVA6Cfg.VLEN-1:0] lookup_pc_i,
    input  logic [GHR_LEN-1:0]      lookup_ghr_i,
    output logic [1:0]              lookup_ctr_o,
    output logic                    lookup_taken_o,
    output logic                    ready_o
);

    localparam int unsigned IW  = $clog2(NR_ENTRIES);
    localparam int unsigned OFF = CVA6Cfg.RVC ? 1 : 2;

    localparam logic [IW-1:0] LAST_IDX = IW'(NR_ENTRIES - 1);

    bht_state_e state_q, state_d;
    logic [IW-1:0] sweep_q, sweep_d;

    ctr_t bht_q [NR_ENTRIES];

    logic [63:0]   upd_pc_ext, upd_ghr_ext, lk_pc_ext, lk_ghr_ext;
    logic [IW-1:0] upd_idx, lk_idx;

    logic          s1_valid_q;
    logic [IW-1:0] s1_idx_q;
    logic          s1_taken_q;

    logic          s1_accept;
    logic          s2_we;
    ctr_t          s2_ctr_old, s2_ctr_new;

    // ---------------- index hashing ----------------
    always_comb begin
        upd_pc_ext  = '0;
        upd_ghr_ext = '0;
        lk_pc_ext   = '0;
        lk_ghr_ext  = '0;
        upd_pc_ext[CVA6Cfg.VLEN-1:0] = update_pc_i;
        upd_ghr_ext[GHR_LEN-1:0]     = update_ghr_i;
        lk_pc_ext[CVA6Cfg.VLEN-1:0]  = lookup_pc_i;
        lk_ghr_ext[GHR_LEN-1:0]      = lookup_ghr_i;
    end

    assign upd_idx = IW'(gshare_index(upd_pc_ext, upd_ghr_ext, OFF, IW));
    assign lk_idx  = IW'(gshare_index(lk_pc_ext, lk_ghr_ext, OFF, IW));

    // ---------------- init / run FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            INIT: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == LAST_IDX) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
                sweep_d = '0;
            end
        endcase
    end

    assign ready_o = (state_q == RUN);

    // ---------------- update pipeline ----------------
    assign s1_accept = update_valid_i & ~debug_mode_i & (state_q == RUN);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_accept;
        end
    end

    always_ff @(posedge clk_i) begin
        s1_idx_q   <= upd_idx;
        s1_taken_q <= update_taken_i;
    end

    // S2 reads the array directly: a back-to-back update to the same index
    // was written at the edge that opened this cycle, so the flop array
    // itself carries the forwarded value into this read.
    assign s2_we      = s1_valid_q & (state_q == RUN);
    assign s2_ctr_old = bht_q[s1_idx_q];

    sat_counter_2b u_sat_counter (
        .ctr      (s2_ctr_old),
        .taken    (s1_taken_q),
        .ctr_next (s2_ctr_new)
    );

    // Table contents are not reset; the INIT sweep is their only initialiser.
    always_ff @(posedge clk_i) begin
        if (state_q == INIT) begin
            bht_q[sweep_q] <= WEAK_NT;
        end else if (s2_we) begin
            bht_q[s1_idx_q] <= s2_ctr_new;
        end
    end

    // ---------------- lookup ----------------
    always_comb begin
        lookup_ctr_o = WEAK_NT;
        if (state_q == RUN) begin
            if (s2_we && (lk_idx == s1_idx_q)) begin
                lookup_ctr_o = s2_ctr_new;
            end else begin
                lookup_ctr_o = bht_q[lk_idx];
            end
        end
    end

    assign lookup_taken_o = lookup_ctr_o[1];

endmodule

// File: tb/tb_bht_gshare_update.sv
// Directed bench for bht_gshare_update with default parameters
// (VLEN=32, RVC=1, 1024 entries, 10 history bits).
module tb_bht_gshare_update;

    logic        clk;
    logic        rst_n;
    logic        debug_mode;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [9:0]  update_ghr;
    logic [31:0] lookup_pc;
    logic [9:0]  lookup_ghr;
    logic [1:0]  lookup_ctr;
    logic        lookup_taken;
    logic        ready;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [1:0] model [1024];

    typedef struct {
        logic [9:0] idx;
        logic [1:0] exp;
        string      tag;
    } sb_t;
    sb_t sbq[$];

    bht_gshare_update dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .debug_mode_i   (debug_mode),
        .update_valid_i (update_valid),
        .update_pc_i    (update_pc),
        .update_taken_i (update_taken),
        .update_ghr_i   (update_ghr),
        .lookup_pc_i    (lookup_pc),
        .lookup_ghr_i   (lookup_ghr),
        .lookup_ctr_o   (lookup_ctr),
        .lookup_taken_o (lookup_taken),
        .ready_o        (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] idx_of(input logic [31:0] pc, input logic [9:0] ghr);
        return pc[10:1] ^ ghr;
    endfunction

    function automatic logic [1:0] sat_model(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd3) ? 2'd3 : c + 2'd1;
        else   return (c == 2'd0) ? 2'd0 : c - 2'd1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one update at a negedge with the lookup aimed at the same index;
    // one edge later that update sits in S2 and the lookup must show its result.
    task automatic upd_step(input logic [31:0] pc, input logic [9:0] ghr,
                            input logic taken, input logic dbg, input string tag);
        sb_t e;
        logic [9:0] i;
        i = idx_of(pc, ghr);
        update_valid = 1'b1;
        update_pc    = pc;
        update_ghr   = ghr;
        update_taken = taken;
        debug_mode   = dbg;
        lookup_pc    = pc;
        lookup_ghr   = ghr;
        if (!dbg) model[i] = sat_model(model[i], taken);
        e.idx = i;
        e.exp = model[i];
        e.tag = tag;
        sbq.push_back(e);
        @(posedge clk);
        @(negedge clk);
        update_valid = 1'b0;
        debug_mode   = 1'b0;
        #1;
        e = sbq.pop_front();
        check({e.tag, "_ctr"}, 32'(lookup_ctr), 32'(e.exp));
        check({e.tag, "_tkn"}, 32'(lookup_taken), 32'(e.exp[1]));
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic look(input logic [9:0] i, input string tag);
        lookup_pc  = {21'd0, i, 1'b0};
        lookup_ghr = 10'd0;
        #1;
        check(tag, 32'(lookup_ctr), 32'(model[i]));
    endtask

    task automatic sweep_all(input string tag);
        for (int i = 0; i < 1024; i++) begin
            look(10'(i), tag);
        end
    endtask

    // Release reset at a negedge and count edges until ready rises.
    task automatic release_and_measure(input string tag, input logic poke_updates);
        int cycles;
        cycles = 0;
        rst_n = 1'b1;
        if (poke_updates) begin
            update_valid = 1'b1;
            update_pc    = 32'h0000_0040;
            update_ghr   = 10'd0;
            update_taken = 1'b1;
        end
        while (cycles < 3000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 100) update_valid = 1'b0;
            if (ready) break;
        end
        update_valid = 1'b0;
        check(tag, 32'(cycles), 32'd1024);
        @(negedge clk);
    endtask

    initial begin
        rst_n        = 1'b0;
        debug_mode   = 1'b0;
        update_valid = 1'b0;
        update_pc    = '0;
        update_taken = 1'b0;
        update_ghr   = '0;
        lookup_pc    = '0;
        lookup_ghr   = '0;
        for (int i = 0; i < 1024; i++) model[i] = 2'b01;

        #2;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_ctr", 32'(lookup_ctr), 32'd1);
        check("rst_taken", 32'(lookup_taken), 32'd0);

        @(negedge clk);
        @(negedge clk);
        release_and_measure("init_cycles", 1'b1);
        check("ready_after_init", 32'(ready), 32'd1);
        sweep_all("init_entry");

        // Three back-to-back taken updates; index 0x3F7 must saturate at 3.
        upd_step(32'h8000_0010, 10'h3FF, 1'b1, 1'b0, "b2b_t0");
        upd_step(32'h8000_0010, 10'h3FF, 1'b1, 1'b0, "b2b_t1");
        upd_step(32'h8000_0010, 10'h3FF, 1'b1, 1'b0, "b2b_t2");
        idle_cycles(2);
        look(10'h3F7, "b2b_final_3f7");
        check("b2b_idx_hash", 32'(idx_of(32'h8000_0010, 10'h3FF)), 32'h3F7);
        upd_step(32'h8000_0010, 10'h3FF, 1'b1, 1'b0, "sat_hi");

        // Four not-taken updates: floor at 0.
        for (int k = 0; k < 4; k++) begin
            upd_step(32'h0000_1234, 10'h055, 1'b0, 1'b0, "nt_floor");
        end
        idle_cycles(2);
        look(idx_of(32'h0000_1234, 10'h055), "nt_final");

        // Debug mode drops the update.
        upd_step(32'h0000_0200, 10'h000, 1'b1, 1'b1, "debug_drop");
        idle_cycles(2);
        look(10'h100, "debug_final");

        // Single taken update: bypass shows 2'b10 in the S2 cycle.
        upd_step(32'h0000_0300, 10'h00A, 1'b1, 1'b0, "bypass_01_10");

        // Mixed directions on one index, then an unrelated index in between.
        upd_step(32'h0000_0500, 10'h001, 1'b1, 1'b0, "mix0");
        upd_step(32'h0000_0500, 10'h001, 1'b1, 1'b0, "mix1");
        upd_step(32'h0000_0500, 10'h001, 1'b0, 1'b0, "mix2");
        upd_step(32'h0000_0700, 10'h002, 1'b0, 1'b0, "mix_other");
        upd_step(32'h0000_0500, 10'h001, 1'b1, 1'b0, "mix3");
        idle_cycles(2);
        look(idx_of(32'h0000_0500, 10'h001), "mix_final");
        look(idx_of(32'h0000_0700, 10'h002), "mix_other_final");

        // Reset mid-RUN with updates in flight.
        update_valid = 1'b1;
        update_pc    = 32'h0000_0600;
        update_ghr   = 10'h000;
        update_taken = 1'b1;
        @(posedge clk);
        @(negedge clk);
        update_pc = 32'h0000_0602;
        #2;
        rst_n = 1'b0;
        update_valid = 1'b0;
        #1;
        check("midrun_rst_ready", 32'(ready), 32'd0);
        check("midrun_rst_ctr", 32'(lookup_ctr), 32'd1);
        for (int i = 0; i < 1024; i++) model[i] = 2'b01;
        @(negedge clk);
        @(negedge clk);
        release_and_measure("midrun_init_cycles", 1'b0);
        sweep_all("midrun_entry");

        check("sb_empty", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
